// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
// Optional: define MULDIV_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_p;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_iter, early_exit;

  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // Division reuses acc[W-1:0] as partial remainder, mplier as dividend/quotient, mcand as divisor.
    shifted  = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    trial    = shifted - {1'b0, mcand[WIDTH-1:0]};
    prod_fix = neg_p ? -acc : acc;
    quo_fix  = neg_p ? -mplier : mplier;
    rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    last_iter = (count == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
    early_exit = ~is_div && (mplier[WIDTH-1:1] == '0);
`else
    early_exit = 1'b0;
`endif
  end

  assign stall = busy & (start | rd_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !op[2]) begin
              is_div <= op[1];
              count  <= '0;
              busy   <= 1'b1;
              acc    <= '0;
              neg_p  <= a_neg ^ b_neg;
              if (op[1]) begin
                mcand  <= {{WIDTH{1'b0}}, b_mag};
                mplier <= a_mag;
                neg_r  <= a_neg;
                state  <= RUN;
                // Divide by zero: HI gets the raw dividend, LO all ones, no sign fix.
                if (b == '0) begin
                  acc    <= {{WIDTH{1'b0}}, a};
                  mplier <= '1;
                  neg_p  <= 1'b0;
                  neg_r  <= 1'b0;
                  state  <= SIGN;
                end
              end else begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                neg_r  <= 1'b0;
                state  <= RUN;
`ifdef MULDIV_EARLY_OUT_EN
                if (b == '0) state <= SIGN;
`endif
              end
            end else if (start && op == 3'd4) begin
              hi <= a;
            end else if (start && op == 3'd5) begin
              lo <= a;
            end
          end
          RUN: begin
            count <= count + 1'b1;
            if (is_div) begin
              if (!trial[WIDTH]) begin
                acc[WIDTH-1:0] <= trial[WIDTH-1:0];
                mplier         <= {mplier[WIDTH-2:0], 1'b1};
              end else begin
                acc[WIDTH-1:0] <= shifted[WIDTH-1:0];
                mplier         <= {mplier[WIDTH-2:0], 1'b0};
              end
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            if (last_iter || early_exit) state <= SIGN;
          end
          SIGN: begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table and sequence checks for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_req = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int exp_busy(input logic [2:0] o, input logic [31:0] bv);
    logic [31:0] mag;
    if (o[1]) return (bv == 0) ? 1 : 33;
`ifdef MULDIV_EARLY_OUT_EN
    mag = (!o[0] && bv[31]) ? -bv : bv;
    if (bv == 0) return 1;
    return (bitlen(mag) < 1 ? 1 : bitlen(mag)) + 1;
`else
    mag = bv;
    return 33 + 0 * bitlen(mag);
`endif
  endfunction

  // Issues one op; reports busy cycles and the edge index (start edge = 1) where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int busy_n, output int done_at);
    busy_n = 0;
    done_at = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bn, da;
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd1, 32'd9,        32'd3,        32'd0,        32'd27};
    vecs[6]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFE};
    vecs[10] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{3'd1, 32'd5,        32'd0,        32'd0,        32'd0};

    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, bn, da);
      chk($sformatf("v%0d_hi", v), hi, vecs[v].hi);
      chk($sformatf("v%0d_lo", v), lo, vecs[v].lo);
      chk($sformatf("v%0d_busy_cycles", v), bn, exp_busy(vecs[v].op, vecs[v].b));
      chk($sformatf("v%0d_done_at", v), da, exp_busy(vecs[v].op, vecs[v].b) + 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", v), done, 0);
    end

    // Stall while busy, second start ignored, MFHI/MFLO in done cycle sees the new value.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 op = 3'd3; a = 32'd100; b = 32'd3; rd_req = 1'b1;
    da = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        da = i;
        chk("seq4_done_lo", lo, 42);
        chk("seq4_done_hi", hi, 0);
        chk("seq4_done_stall", stall, 0);
        start = 1'b0; rd_req = 1'b0;
        break;
      end
      chk($sformatf("seq4_stall_c%0d", i), stall, 1);
      @(posedge clk); #1;
    end
    chk("seq4_done_seen", (da != 0), 1);
    start = 1'b0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("seq4_second_ignored_busy", busy, 0);
    chk("seq4_second_ignored_lo", lo, 42);

    // MTHI / MTLO.
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'h1234;
    @(posedge clk); #1 start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_done", done, 0);
    chk("mthi_busy", busy, 0);
    @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h5678;
    @(posedge clk); #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_done", done, 0);

    // flush with start in IDLE drops the op.
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", hi, 32'h1234);

    // flush during a DIV.
    @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    da = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) da = 1;
    end
    chk("flush_no_done", da, 0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);

    // Asynchronous reset mid-RUN.
    @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd11; b = 32'd13;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk); reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_after_lo", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
